// File: rtl/button_bank.sv
// Multi-channel active-low push-button front end: sync, debounce, press/release/long pulses.
// Define BUTTON_BANK_REPEAT_EN to build the per-channel auto-repeat counters.

module button_bank_lane #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic button,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic press_evt
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] cnt, cnt_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [1:0]    sync_pipe;
    logic          s, held, rel_evt, long_evt;

    // Sync flops idle high so reset looks like a released button.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) sync_pipe <= 2'b11;
        else       sync_pipe <= {sync_pipe[0], button};
    end
    assign s    = sync_pipe[1];
    assign held = (state == HELD) || (state == REL_CHK);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_evt = 1'b0;
        rel_evt   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = HELD;
                        press_evt = 1'b1;
                    end else begin
                        state_nxt = PRESS_CHK;
                        cnt_nxt   = DW'(1);
                    end
                end
            end
            PRESS_CHK: begin
                if (s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    press_evt = 1'b1;
                end else begin
                    cnt_nxt = cnt + DW'(1);
                end
            end
            HELD: begin
                cnt_nxt = '0;
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = IDLE;
                        rel_evt   = 1'b1;
                    end else begin
                        state_nxt = REL_CHK;
                        cnt_nxt   = DW'(1);
                    end
                end
            end
            REL_CHK: begin
                if (!s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    rel_evt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + DW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Hold age restarts on every fresh press and parks at LONG_CYCLES.
        hold_nxt = '0;
        if (held) hold_nxt = (hold_cnt == LONG_MAX) ? hold_cnt : hold_cnt + HW'(1);
        long_evt = held && (hold_cnt == LONG_LAST);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            cnt           <= '0;
            hold_cnt      <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            hold_cnt      <= hold_nxt;
            pressed       <= (state_nxt == HELD) || (state_nxt == REL_CHK);
            press_pulse   <= press_evt;
            release_pulse <= rel_evt;
            long_pulse    <= long_evt;
        end
    end

`ifdef BUTTON_BANK_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt, rep_nxt;
    logic          rep_evt;

    // Repeat phase runs only once the hold age has saturated.
    always_comb begin
        rep_nxt = '0;
        rep_evt = 1'b0;
        if (held && hold_cnt == LONG_MAX) begin
            if (rep_cnt == REP_LAST) rep_evt = 1'b1;
            else                     rep_nxt = rep_cnt + RW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rep_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            rep_cnt      <= rep_nxt;
            repeat_pulse <= rep_evt;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif
endmodule

module button_bank #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [CHANNELS-1:0] buttons,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic                any_press
);
    logic [CHANNELS-1:0] press_evt;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        button_bank_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_lane (
            .CLK          (CLK),
            .RESET        (RESET),
            .button       (buttons[i]),
            .pressed      (pressed[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .long_pulse   (long_pulse[i]),
            .repeat_pulse (repeat_pulse[i]),
            .press_evt    (press_evt[i])
        );
    end

    // Built from the lanes' pre-register events so it lands with press_pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) any_press <= 1'b0;
        else       any_press <= |press_evt;
    end
endmodule

// File: tb/tb_button_bank.sv
// Bench for button_bank: directed scenarios plus random button traffic against a
// sample-window reference model (acceptance = last DEBOUNCE synchronised samples agree).

module tb_button_bank;
    localparam int CH = 4, DB = 4, LC = 20, RC = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [CH-1:0] buttons;
    logic [CH-1:0] pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic          any_press;

    button_bank #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC)) dut (
        .CLK(CLK), .RESET(RESET), .buttons(buttons), .pressed(pressed),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse), .any_press(any_press)
    );

    always #5 CLK = ~CLK;

    int            checks = 0, errors = 0;
    logic [CH-1:0] hist[$];
    logic [CH-1:0] lvl;
    int            pedge[CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Synchroniser resets high, so the pre-reset history reads as released.
    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DB + 2; i++) hist.push_back('1);
        lvl = '0;
        for (int c = 0; c < CH; c++) pedge[c] = 0;
    endtask

    task automatic tick();
        logic [CH-1:0] smp, e_press, e_rel, e_long, e_rep;
        bit            all0, all1;
        int            last, age;
        @(posedge CLK);
        hist.push_back(buttons);
        last    = hist.size() - 1;
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        for (int c = 0; c < CH; c++) begin
            all0 = 1'b1; all1 = 1'b1;
            // The FSM at this edge decides on captures from edges last-DB-1 .. last-2.
            for (int k = 2; k <= DB + 1; k++) begin
                smp = hist[last - k];
                if (smp[c]) all0 = 1'b0; else all1 = 1'b0;
            end
            if (lvl[c]) begin
                age = last - pedge[c];
                if (age == LC) e_long[c] = 1'b1;
`ifdef BUTTON_BANK_REPEAT_EN
                if (age > LC && (age - LC) % RC == 0) e_rep[c] = 1'b1;
`endif
                if (all1) begin lvl[c] = 1'b0; e_rel[c] = 1'b1; end
            end else if (all0) begin
                lvl[c] = 1'b1; e_press[c] = 1'b1; pedge[c] = last;
            end
        end
        #1;
        chk("pressed", pressed, lvl);
        chk("press_pulse", press_pulse, e_press);
        chk("release_pulse", release_pulse, e_rel);
        chk("long_pulse", long_pulse, e_long);
        chk("repeat_pulse", repeat_pulse, e_rep);
        chk("any_press", any_press, |e_press);
    endtask

    // kind: 0 press, 1 release, 2 long. t = ticks until seen, -1 if budget ran out.
    task automatic wait_for(input int c, input int kind, input int budget, output int t);
        logic [CH-1:0] v;
        t = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            v = (kind == 0) ? press_pulse : (kind == 1) ? release_pulse : long_pulse;
            if (v[c]) begin t = i; break; end
        end
    endtask

    initial begin
        int t, nl, li, nr, fr, np;
        RESET   = 1'b1;
        buttons = '1;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_pressed", pressed, 0);
        chk("rst_press", press_pulse, 0);
        chk("rst_any", any_press, 0);
        #1 RESET = 1'b0;
        repeat (3) tick();

        // Clean press on channel 0, then a 2-cycle glitch high while held.
        buttons[0] = 1'b0;
        wait_for(0, 0, 20, t);
        chk("press0_latency", t, 6);
        chk("press0_only", press_pulse, 4'b0001);
        tick();
        chk("press0_width", press_pulse, 4'b0000);
        repeat (6) tick();
        buttons[0] = 1'b1;
        repeat (2) tick();
        buttons[0] = 1'b0;
        wait_for(0, 2, 40, t);
        chk("long0_after_glitch", t, 11);
        chk("pressed0_after_glitch", pressed[0], 1);
        repeat (3) tick();
        buttons[0] = 1'b1;
        wait_for(0, 1, 20, t);
        chk("release0_latency", t, 6);
        chk("release0_pressed_low", pressed[0], 0);
        repeat (3) tick();

        // Bouncing press on channel 2.
        buttons[2] = 1'b0;
        repeat (3) tick();
        buttons[2] = 1'b1;
        tick();
        buttons[2] = 1'b0;
        wait_for(2, 0, 20, t);
        chk("bounce2_latency", t, 6);
        np = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (press_pulse[2]) np++; end
        chk("bounce2_single", np, 0);
        buttons[2] = 1'b1;
        wait_for(2, 1, 20, t);
        chk("release2_latency", t, 6);

        // Long hold on channel 1.
        buttons[1] = 1'b0;
        wait_for(1, 0, 20, t);
        chk("press1_latency", t, 6);
        nl = 0; li = 0; nr = 0; fr = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (long_pulse[1]) begin nl++; li = i; end
            if (repeat_pulse[1]) begin nr++; if (fr == 0) fr = i; end
        end
        chk("long1_count", nl, 1);
        chk("long1_offset", li, LC);
`ifdef BUTTON_BANK_REPEAT_EN
        chk("repeat1_count", nr, 5);
        chk("repeat1_first", fr, LC + RC);
`else
        chk("repeat1_count", nr, 0);
`endif
        buttons[1] = 1'b1;
        wait_for(1, 1, 20, t);
        chk("release1_latency", t, 6);
        repeat (3) tick();

        // Simultaneous press on channels 1 and 3.
        buttons[1] = 1'b0;
        buttons[3] = 1'b0;
        wait_for(1, 0, 20, t);
        chk("dual_latency", t, 6);
        chk("dual_press", press_pulse, 4'b1010);
        chk("dual_any", any_press, 1);
        tick();
        chk("dual_any_width", any_press, 0);

        // Async reset right after long_pulse, buttons still low.
        wait_for(1, 2, 30, t);
        chk("dual_long", t, LC - 1);
        #1 RESET = 1'b1;
        #1;
        chk("async_pressed", pressed, 0);
        chk("async_long", long_pulse, 0);
        chk("async_repeat", repeat_pulse, 0);
        repeat (2) @(posedge CLK);
        #1;
        chk("inreset_press", press_pulse, 0);
        chk("inreset_any", any_press, 0);
        #1 RESET = 1'b0;
        model_reset();
        wait_for(1, 0, 20, t);
        chk("post_reset_latency", t, 6);
        chk("post_reset_press", press_pulse, 4'b1010);
        buttons = '1;
        repeat (10) tick();

        // Random button traffic.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 11) == 0) buttons[c] = ~buttons[c];
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
